// File: rtl/tab_arq_arbiter_if.sv
// -----------------------------------------------------------------------------
// tab_arq_arbiter_if
// Bundles the two requester handshakes and the file-table access bus.
//   req<n>_valid/ready/we/addr/wdata : request channel of requester n
//   resp<n>_valid/rdata/err          : one-cycle response of requester n
//   tab_endereco/dados_esc/op        : table address, write data, write enable
//   tab_dados_lid                    : table read data (combinational)
// Modports:
//   slave  : the arbiter side (receives requests, drives the table)
//   master : the environment side (requesters and the table itself)
// -----------------------------------------------------------------------------
interface tab_arq_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          resp0_valid;
    logic [DW-1:0] resp0_rdata;
    logic          resp0_err;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          resp1_valid;
    logic [DW-1:0] resp1_rdata;
    logic          resp1_err;

    logic [AW-1:0] tab_endereco;
    logic [DW-1:0] tab_dados_esc;
    logic          tab_op;
    logic [DW-1:0] tab_dados_lid;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_rdata, resp0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_rdata, resp1_err,
        output tab_endereco, tab_dados_esc, tab_op,
        input  tab_dados_lid
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
        input  tab_endereco, tab_dados_esc, tab_op,
        output tab_dados_lid
    );
endinterface

// File: rtl/tab_arq_arbiter.sv
// -----------------------------------------------------------------------------
// tab_arq_arbiter
// Shares the file table (DEPTH x DW, synchronous write, asynchronous read)
// between requester 0 (CPU datapath) and requester 1 (IO/loader).
// Round-robin arbitration on ties; each accepted request runs
// IDLE -> ACCESS -> RESP -> IDLE, i.e. one table access and one response
// pulse, giving one request every three cycles.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : tab_arq_arbiter_if.slave (requests, responses, table bus)
// Out-of-range addresses (addr >= DEPTH) are answered with err=1 and never
// raise the table write enable.
// -----------------------------------------------------------------------------
module tab_arq_arbiter #(
    parameter int DEPTH = 201,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic            clock,
    input  logic            reset,
    tab_arq_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_t        state_r;
    state_t        state_s;
    logic          last_grant_r;
    logic          id_r;
    logic          we_r;
    logic          err_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          tab_op_r;

    logic          resp0_valid_r;
    logic          resp1_valid_r;
    logic          resp0_err_r;
    logic          resp1_err_r;
    logic [DW-1:0] resp0_rdata_r;
    logic [DW-1:0] resp1_rdata_r;

    logic          grant0_s;
    logic          grant1_s;
    logic          accept_s;
    logic          sel_we_s;
    logic          sel_err_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          rd_ok_s;

    // Winner selection (IDLE only) and next-state decode
    always_comb begin
        state_s  = state_r;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // On a tie the requester that was not served last wins;
                // last_grant_r resets to 1 so requester 0 takes the first tie.
                if (bus.req0_valid && (!bus.req1_valid || last_grant_r)) begin
                    grant0_s = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
                if (grant0_s || grant1_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Fields of the winning request, selected for capture at the handshake
    always_comb begin
        accept_s = grant0_s | grant1_s;
        if (grant1_s) begin
            sel_we_s    = bus.req1_we;
            sel_addr_s  = bus.req1_addr;
            sel_wdata_s = bus.req1_wdata;
        end else begin
            sel_we_s    = bus.req0_we;
            sel_addr_s  = bus.req0_addr;
            sel_wdata_s = bus.req0_wdata;
        end
        // Full-width compare so any upper address bit flags an error
        sel_err_s = (sel_addr_s >= DEPTH_W);
        rd_ok_s   = (state_r == ST_ACCESS) && !we_r && !err_r;
    end

    // Ready is combinational so the handshake completes in the IDLE cycle
    assign bus.req0_ready = grant0_s & ~reset;
    assign bus.req1_ready = grant1_s & ~reset;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture of the accepted request and round-robin history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            we_r         <= 1'b0;
            err_r        <= 1'b0;
            addr_r       <= {AW{1'b0}};
            wdata_r      <= {DW{1'b0}};
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
            id_r         <= grant1_s;
            we_r         <= sel_we_s;
            err_r        <= sel_err_s;
            addr_r       <= sel_addr_s;
            wdata_r      <= sel_wdata_s;
        end else begin
            last_grant_r <= last_grant_r;
            id_r         <= id_r;
            we_r         <= we_r;
            err_r        <= err_r;
            addr_r       <= addr_r;
            wdata_r      <= wdata_r;
        end
    end

    // Table write enable: a dedicated flop that is high only for the ACCESS
    // cycle of an in-range write, so it is glitch-free and reset kills it at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tab_op_r <= 1'b0;
        end else begin
            tab_op_r <= accept_s & sel_we_s & ~sel_err_s;
        end
    end

    // Response registers: loaded at the end of ACCESS, so they show during RESP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            resp0_err_r   <= 1'b0;
            resp1_err_r   <= 1'b0;
            resp0_rdata_r <= {DW{1'b0}};
            resp1_rdata_r <= {DW{1'b0}};
        end else begin
            resp0_valid_r <= (state_r == ST_ACCESS) && !id_r;
            resp1_valid_r <= (state_r == ST_ACCESS) &&  id_r;
            resp0_err_r   <= (state_r == ST_ACCESS) && !id_r && err_r;
            resp1_err_r   <= (state_r == ST_ACCESS) &&  id_r && err_r;
            resp0_rdata_r <= (rd_ok_s && !id_r) ? bus.tab_dados_lid : {DW{1'b0}};
            resp1_rdata_r <= (rd_ok_s &&  id_r) ? bus.tab_dados_lid : {DW{1'b0}};
        end
    end

    // addr_r only changes on a handshake, so the table address stays stable
    // from ACCESS through RESP
    assign bus.tab_endereco  = addr_r;
    assign bus.tab_dados_esc = wdata_r;
    assign bus.tab_op        = tab_op_r;
    assign bus.resp0_valid   = resp0_valid_r;
    assign bus.resp1_valid   = resp1_valid_r;
    assign bus.resp0_err     = resp0_err_r;
    assign bus.resp1_err     = resp1_err_r;
    assign bus.resp0_rdata   = resp0_rdata_r;
    assign bus.resp1_rdata   = resp1_rdata_r;

endmodule

// File: tb/tb_tab_arq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tab_arq_arbiter
// Requester queues feed a driver; a negedge monitor records handshakes,
// predicts each response from a plain array model of the table and checks
// responses, table write strobes and ready behaviour against a scoreboard.
// -----------------------------------------------------------------------------
module tb_tab_arq_arbiter;

    localparam int DEPTH = 201;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        bit          id;
        bit          err;
        logic [31:0] rdata;
        bit          kn;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;

    tab_arq_arbiter_if #(.AW(32), .DW(32)) bus ();

    tab_arq_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // ---------------- table environment ----------------
    logic [31:0] tab_mem [0:DEPTH-1];
    bit          mem_clr;

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) tab_mem[i] <= 32'd0;
        end else if (bus.tab_op && bus.tab_endereco < DEPTH) begin
            tab_mem[bus.tab_endereco] <= bus.tab_dados_esc;
        end
    end

    assign bus.tab_dados_lid = (bus.tab_endereco < DEPTH) ? tab_mem[bus.tab_endereco] : 32'd0;

    // ---------------- bookkeeping ----------------
    int          n_vec;
    int          n_err;
    int          ncyc;
    int          n_resp;
    int          exp_op_cyc;
    logic [31:0] exp_op_addr;
    logic [31:0] exp_op_data;
    int          busy_until;
    exp_t        sb[$];
    req_t        rq0[$];
    req_t        rq1[$];
    bit          grant_log[$];
    bit          hs[2];
    bit          act[2];
    logic [31:0] ref_mem [0:DEPTH-1];
    bit          known [0:DEPTH-1];

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    // Reference model of one accepted request: the table is an array and
    // requests are served strictly in handshake order.
    task automatic take(input bit id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.id    = id;
        e.err   = (addr >= DEPTH);
        e.rdata = 32'd0;
        e.kn    = 1'b1;
        e.cyc   = ncyc + 2;
        if (!e.err && we) begin
            ref_mem[addr] = wdata;
            known[addr]   = 1'b1;
        end else if (!e.err) begin
            e.rdata = ref_mem[addr];
            e.kn    = known[addr];
        end
        sb.push_back(e);
        exp_op_cyc  = (we && !e.err) ? ncyc + 1 : -1;
        exp_op_addr = addr;
        exp_op_data = wdata;
        busy_until  = ncyc + 2;
        grant_log.push_back(id);
        hs[id] = 1'b1;
    endtask

    // Monitor: sample away from the rising edge, check and then record handshakes
    always @(negedge clock) begin
        ncyc++;
        if (reset) begin
            chk("reset_outs",
                {bus.resp0_valid, bus.resp1_valid, bus.resp0_err, bus.resp1_err, bus.tab_op,
                 bus.req0_ready, bus.req1_ready, |bus.resp0_rdata, |bus.resp1_rdata,
                 |bus.tab_endereco, |bus.tab_dados_esc}, 64'd0);
            sb.delete();
            exp_op_cyc = -1;
            busy_until = -1;
            hs[0] = 1'b0;
            hs[1] = 1'b0;
        end else begin
            chk("two_ready", bus.req0_ready & bus.req1_ready, 64'd0);
            chk("tab_op", bus.tab_op, (ncyc == exp_op_cyc));
            if (ncyc == exp_op_cyc) begin
                chk("tab_addr", bus.tab_endereco, exp_op_addr);
                chk("tab_wdata", bus.tab_dados_esc, exp_op_data);
            end
            if (ncyc <= busy_until) chk("ready_busy", bus.req0_ready | bus.req1_ready, 64'd0);
            if (bus.resp0_valid || bus.resp1_valid) begin
                n_resp++;
                chk("resp_both", bus.resp0_valid & bus.resp1_valid, 64'd0);
                chk("resp_expected", (sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_port", bus.resp1_valid, e.id);
                    chk("resp_cycle", ncyc, e.cyc);
                    if (e.id) begin
                        chk("resp1_err", bus.resp1_err, e.err);
                        if (e.kn) chk("resp1_rdata", bus.resp1_rdata, e.rdata);
                    end else begin
                        chk("resp0_err", bus.resp0_err, e.err);
                        if (e.kn) chk("resp0_rdata", bus.resp0_rdata, e.rdata);
                    end
                end
            end else begin
                chk("resp_idle", {bus.resp0_err, bus.resp1_err, |bus.resp0_rdata, |bus.resp1_rdata}, 64'd0);
                if (sb.size() != 0) begin
                    chk("resp_timeout", (ncyc <= sb[0].cyc), 64'd1);
                    if (ncyc > sb[0].cyc) void'(sb.pop_front());
                end
            end
            if (bus.req0_valid && bus.req0_ready)
                take(1'b0, bus.req0_we, bus.req0_addr, bus.req0_wdata);
            else if (bus.req1_valid && bus.req1_ready)
                take(1'b1, bus.req1_we, bus.req1_addr, bus.req1_wdata);
        end
    end

    // Driver: after each rising edge retire handshaken requests, load queued ones
    initial begin
        req_t r;
        forever begin
            @(posedge clock);
            #1;
            if (hs[0]) begin bus.req0_valid = 1'b0; hs[0] = 1'b0; act[0] = 1'b0; end
            if (hs[1]) begin bus.req1_valid = 1'b0; hs[1] = 1'b0; act[1] = 1'b0; end
            if (!act[0] && rq0.size() != 0) begin
                r = rq0.pop_front();
                bus.req0_we = r.we; bus.req0_addr = r.addr; bus.req0_wdata = r.wdata;
                bus.req0_valid = 1'b1; act[0] = 1'b1;
            end
            if (!act[1] && rq1.size() != 0) begin
                r = rq1.pop_front();
                bus.req1_we = r.we; bus.req1_addr = r.addr; bus.req1_wdata = r.wdata;
                bus.req1_valid = 1'b1; act[1] = 1'b1;
            end
        end
    end

    task automatic push_req(input bit id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        if (id) rq1.push_back(r);
        else    rq0.push_back(r);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clock);
            #1;
            done = (rq0.size() == 0) && (rq1.size() == 0) && !act[0] && !act[1] &&
                   (sb.size() == 0) && (ncyc > busy_until);
        end
        chk("idle_reached", done, 64'd1);
    endtask

    task automatic chk_grants(input string name, input int s, input int n, input bit first);
        chk({name, "_count"}, (grant_log.size() >= s + n), 64'd1);
        if (grant_log.size() >= s + n) begin
            for (int i = 0; i < n; i++) chk(name, grant_log[s+i], first ^ i[0]);
        end
    endtask

    initial begin : stim
        int s;
        int r0;
        int g;
        clock = 1'b0;
        reset = 1'b1;
        mem_clr = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = 32'd0; bus.req0_wdata = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = 32'd0; bus.req1_wdata = 32'd0;
        n_vec = 0; n_err = 0; ncyc = 0; n_resp = 0;
        exp_op_cyc = -1; busy_until = -1;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 32'd0; known[i] = 1'b1; end
        repeat (3) @(negedge clock);

        // Tie straight out of reset: requester 0 first, then requester 1
        s = grant_log.size();
        push_req(1'b0, 1'b0, 32'd3, 32'd0);
        push_req(1'b1, 1'b0, 32'd4, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        mem_clr = 1'b0;
        wait_idle();
        chk_grants("tie_from_reset", s, 2, 1'b0);

        // Write then read back on requester 0
        push_req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        push_req(1'b0, 1'b0, 32'd5, 32'd0);
        wait_idle();

        // Out-of-range writes on requester 1, then address 5 must be untouched
        push_req(1'b1, 1'b1, 32'd201, 32'h1111_1111);
        push_req(1'b1, 1'b1, 32'h8000_0005, 32'h2222_2222);
        push_req(1'b1, 1'b0, 32'd5, 32'd0);
        push_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
        wait_idle();

        // Top valid entry
        push_req(1'b1, 1'b1, 32'd200, 32'h0000_00C8);
        push_req(1'b1, 1'b0, 32'd200, 32'd0);
        wait_idle();

        // Sustained contention: grants alternate starting with requester 0
        s  = grant_log.size();
        r0 = n_resp;
        push_req(1'b0, 1'b1, 32'd10, 32'hA0A0_0001);
        push_req(1'b0, 1'b0, 32'd11, 32'd0);
        push_req(1'b1, 1'b0, 32'd10, 32'd0);
        push_req(1'b1, 1'b1, 32'd11, 32'hB1B1_0002);
        wait_idle();
        chk_grants("contention", s, 4, 1'b0);
        chk("contention_resps", n_resp - r0, 64'd4);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            push_req($urandom_range(0, 1),
                     $urandom_range(0, 1),
                     ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 210),
                     $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clock);
        end
        wait_idle();

        // Reset in the middle of a write's ACCESS cycle
        g = grant_log.size();
        push_req(1'b0, 1'b1, 32'd7, 32'h1234_5678);
        for (int i = 0; i < 20 && grant_log.size() == g; i++) @(negedge clock);
        chk("reset_test_grant", (grant_log.size() > g), 64'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("tab_op_async_drop", bus.tab_op, 64'd0);
        chk("no_resp_in_reset", {bus.resp0_valid, bus.resp1_valid}, 64'd0);
        known[7] = 1'b0;
        @(negedge clock);
        s = grant_log.size();
        push_req(1'b0, 1'b0, 32'd7, 32'd0);
        push_req(1'b1, 1'b0, 32'd10, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        wait_idle();
        chk_grants("tie_after_reset", s, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d miscompares so far", n_err);
        $fatal(1, "watchdog");
    end

endmodule
